fib_seq_ctrl: RTL

- Parametrised control sequencer for the register-file/ALU datapath.
- Generates per-cycle ALU opcode, A/B source selects, one-hot register write enables and immediate, so the datapath computes a programmable recurrence into the register file.
- Supports runtime seeds, term count, Fibonacci-style (add) or arithmetic-progression (addi) mode, register wrap-around, hold and a start/busy/done handshake.
- Sits where the fixed 16-step Fibonacci FSM sits today.

---
 rtl/fib_seq_ctrl_if.sv | 39 +++
 rtl/fib_seq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_ctrl_if.sv
// Control/handshake bundle between fib_seq_ctrl and its surroundings.
// master: the sequencer (requests and seeds in; ALU/regfile controls and status out).
// slave : the requester/datapath side (mirror of master).
// Ports: start, hold, mode, wrap_en, seed0, seed1, num_terms (to sequencer);
//        alu_op, mux_a, mux_b, regs_en, imm, busy, done, term_idx (from sequencer).
interface fib_seq_ctrl_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned OP_W     = 8,
  parameter int unsigned CNT_W    = 16
);
  logic                start;
  logic                hold;
  logic                mode;
  logic                wrap_en;
  logic [DATA_W-1:0]   seed0;
  logic [DATA_W-1:0]   seed1;
  logic [CNT_W-1:0]    num_terms;

  logic [OP_W-1:0]     alu_op;
  logic [SEL_W-1:0]    mux_a;
  logic [SEL_W-1:0]    mux_b;
  logic [NUM_REGS-1:0] regs_en;
  logic [DATA_W-1:0]   imm;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    term_idx;

  modport master (
    input  start, hold, mode, wrap_en, seed0, seed1, num_terms,
    output alu_op, mux_a, mux_b, regs_en, imm, busy, done, term_idx
  );

  modport slave (
    output start, hold, mode, wrap_en, seed0, seed1, num_terms,
    input  alu_op, mux_a, mux_b, regs_en, imm, busy, done, term_idx
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Control sequencer that drives the register-file/ALU datapath through a
// programmable recurrence: two seed loads, then N-2 add (Fibonacci-style) or
// add-immediate (arithmetic progression) steps, with hold and start/done.
// Ports: clk (rising edge), reset (synchronous, active-high),
//        bus (fib_seq_ctrl_if.master) carrying request inputs and all
//        registered control/status outputs.
module fib_seq_ctrl #(
  parameter int unsigned    DATA_W   = 16,
  parameter int unsigned    NUM_REGS = 16,
  parameter int unsigned    SEL_W    = 4,
  parameter int unsigned    OP_W     = 8,
  parameter int unsigned    CNT_W    = 16,
  parameter logic [OP_W-1:0] OP_NOP  = 8'h00,
  parameter logic [OP_W-1:0] OP_ADD  = 8'h05,
  parameter logic [OP_W-1:0] OP_ADDI = 8'h50,
  parameter logic [OP_W-1:0] OP_LDI  = 8'hF0
) (
  input logic            clk,
  input logic            reset,
  fib_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED0 = 3'd1,
    S_SEED1 = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    term_q, term_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [DATA_W-1:0]   seed0_q, seed0_d;
  logic [DATA_W-1:0]   seed1_q, seed1_d;
  logic                mode_q, mode_d;
  logic                held_q, held_d;

  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [SEL_W-1:0]    mux_a_q, mux_a_d;
  logic [SEL_W-1:0]    mux_b_q, mux_b_d;
  logic [NUM_REGS-1:0] regs_en_q, regs_en_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CNT_W-1:0]    n_eff;
  logic [SEL_W-1:0]    dst;

  // Effective term count: at least the two seeds; without wrap, no more than the file depth.
  always_comb begin
    n_eff = bus.num_terms;
    if (bus.num_terms < CNT_W'(2)) begin
      n_eff = CNT_W'(2);
    end
    if (!bus.wrap_en && (n_eff > CNT_W'(NUM_REGS))) begin
      n_eff = CNT_W'(NUM_REGS);
    end
  end

  // Next-state logic. A held cycle (held_q) suppresses the write and freezes sequencing.
  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    n_d     = n_q;
    seed0_d = seed0_q;
    seed1_d = seed1_q;
    mode_d  = mode_q;
    held_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SEED0;
          term_d  = '0;
          n_d     = n_eff;
          seed0_d = bus.seed0;
          seed1_d = bus.seed1;
          mode_d  = bus.mode;
        end
      end
      S_SEED0: begin
        if (!held_q) begin
          state_d = S_SEED1;
          term_d  = CNT_W'(1);
        end
      end
      S_SEED1: begin
        if (!held_q) begin
          term_d  = CNT_W'(2);
          state_d = (n_q > CNT_W'(2)) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (!held_q) begin
          term_d = term_q + CNT_W'(1);
          if (term_q == (n_q - CNT_W'(1))) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        term_d  = '0;
      end
    endcase

    // Hold sampled now blanks the following cycle, but only while a sequence is active.
    held_d = bus.hold &&
             ((state_d == S_SEED0) || (state_d == S_SEED1) || (state_d == S_RUN));
  end

  // Output decode of the upcoming state so every output leaves a flop.
  always_comb begin
    alu_op_d  = OP_NOP;
    mux_a_d   = '0;
    mux_b_d   = '0;
    regs_en_d = '0;
    imm_d     = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    dst       = SEL_W'(term_d);

    unique case (state_d)
      S_SEED0: begin
        busy_d = 1'b1;
        if (!held_d) begin
          alu_op_d  = OP_LDI;
          imm_d     = seed0_d;
          regs_en_d = NUM_REGS'(1);
        end
      end
      S_SEED1: begin
        busy_d = 1'b1;
        if (!held_d) begin
          alu_op_d  = mode_d ? OP_ADDI : OP_LDI;
          imm_d     = seed1_d;
          regs_en_d = NUM_REGS'(2);
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        if (!held_d) begin
          regs_en_d = NUM_REGS'(1) << dst;
          if (mode_d) begin
            alu_op_d = OP_ADDI;
            mux_a_d  = dst - SEL_W'(1);
            imm_d    = seed1_d;
          end else begin
            alu_op_d = OP_ADD;
            mux_a_d  = dst - SEL_W'(2);
            mux_b_d  = dst - SEL_W'(1);
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      term_q    <= '0;
      n_q       <= '0;
      seed0_q   <= '0;
      seed1_q   <= '0;
      mode_q    <= 1'b0;
      held_q    <= 1'b0;
      alu_op_q  <= OP_NOP;
      mux_a_q   <= '0;
      mux_b_q   <= '0;
      regs_en_q <= '0;
      imm_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      term_q    <= term_d;
      n_q       <= n_d;
      seed0_q   <= seed0_d;
      seed1_q   <= seed1_d;
      mode_q    <= mode_d;
      held_q    <= held_d;
      alu_op_q  <= alu_op_d;
      mux_a_q   <= mux_a_d;
      mux_b_q   <= mux_b_d;
      regs_en_q <= regs_en_d;
      imm_q     <= imm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.alu_op   = alu_op_q;
  assign bus.mux_a    = mux_a_q;
  assign bus.mux_b    = mux_b_q;
  assign bus.regs_en  = regs_en_q;
  assign bus.imm      = imm_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.term_idx = term_q;

endmodule
